irq_controller: RTL

- Prioritised interrupt controller between the board's 8 external interrupt lines and the CPU's single interrupt request input.
- Synchronises and edge/level-qualifies the requests, masks them, and resolves priority (line 0 highest) with nesting support.
- Drives a request/acknowledge handshake to the CPU with a stable 3-bit vector.
- Configured by the CPU through a small 4-register I/O port.

---
 rtl/irq_controller.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/irq_controller.sv
`timescale 1ns/1ps
`default_nettype none
// ----------------------------------------------------------------------------
// irq_controller : 8-line prioritised interrupt controller with a CPU
//                  request/ack handshake and a 4-register configuration port.
// Revision 1.0
// ----------------------------------------------------------------------------
module irq_controller #(
  parameter int NUM_IRQ     = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic               clk,
  input  logic               arst,
  input  logic [NUM_IRQ-1:0] ext_irq_req,
  input  logic               cfg_wr,
  input  logic               cfg_rd,
  input  logic [1:0]         cfg_addr,
  input  logic [7:0]         cfg_wdata,
  output logic [7:0]         cfg_rdata,
  output logic               irq_out,
  output logic [2:0]         irq_vector,
  input  logic               irq_ack
);

  localparam logic [1:0] ADDR_MASK = 2'd0;
  localparam logic [1:0] ADDR_ESEL = 2'd1;
  localparam logic [1:0] ADDR_PEND = 2'd2;
  localparam logic [1:0] ADDR_ISR  = 2'd3;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_REQ  = 1'b1
  } state_t;

  state_t state_q, state_d;

  logic [NUM_IRQ-1:0] sync_q [SYNC_STAGES];
  logic [NUM_IRQ-1:0] s_d_q;
  logic [NUM_IRQ-1:0] mask_q, edge_sel_q, edge_pend_q, in_service_q;
  logic [NUM_IRQ-1:0] edge_sel_d, edge_pend_d, in_service_d;
  logic [2:0]         vector_q, vector_d;

  logic [NUM_IRQ-1:0] s_lvl, rise, eff_pend;
  logic [NUM_IRQ-1:0] vec_onehot, eoi_onehot, ep_clr;
  logic               cand_valid, isr_any, cand_ok, latched_ok, ack_take;
  logic [2:0]         cand_idx, isr_low;
  logic               wr_mask, wr_esel, wr_pend, wr_eoi;
  logic [7:0]         rd_word;

  assign wr_mask = cfg_wr && (cfg_addr == ADDR_MASK);
  assign wr_esel = cfg_wr && (cfg_addr == ADDR_ESEL);
  assign wr_pend = cfg_wr && (cfg_addr == ADDR_PEND);
  assign wr_eoi  = cfg_wr && (cfg_addr == ADDR_ISR);

  assign s_lvl    = sync_q[SYNC_STAGES-1];
  assign rise     = s_lvl & ~s_d_q;
  // Level-mode lines bypass the pending flops entirely.
  assign eff_pend = (edge_sel_q & edge_pend_q) | (~edge_sel_q & s_lvl);

  always_ff @(posedge clk) begin
    if (!arst) begin
      for (int k = 0; k < SYNC_STAGES; k++) sync_q[k] <= '0;
      s_d_q <= '0;
    end else begin
      sync_q[0] <= ext_irq_req;
      for (int k = 1; k < SYNC_STAGES; k++) sync_q[k] <= sync_q[k-1];
      s_d_q <= s_lvl;
    end
  end

  always_comb begin
    cand_valid = 1'b0;
    cand_idx   = '0;
    isr_any    = 1'b0;
    isr_low    = '0;
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      if (eff_pend[i] && mask_q[i]) begin
        cand_valid = 1'b1;
        cand_idx   = 3'(i);
      end
      if (in_service_q[i]) begin
        isr_any = 1'b1;
        isr_low = 3'(i);
      end
    end
  end

  // Strict preemption: only a line above every in-service line may request.
  assign cand_ok    = cand_valid && (!isr_any || (cand_idx < isr_low));
  assign latched_ok = eff_pend[vector_q] && mask_q[vector_q] &&
                      (!isr_any || (vector_q < isr_low));

  always_comb begin
    state_d  = state_q;
    vector_d = vector_q;
    ack_take = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (cand_ok) begin
          state_d  = ST_REQ;
          vector_d = cand_idx;
        end
      end
      ST_REQ: begin
        if (irq_ack) begin
          ack_take = 1'b1;
          state_d  = ST_IDLE;
        end else if (!latched_ok) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    vec_onehot           = '0;
    vec_onehot[vector_q] = 1'b1;
    eoi_onehot           = '0;
    eoi_onehot[isr_low]  = isr_any;

    // EOI retires the old lowest bit before the ack adds its own.
    in_service_d = (in_service_q & ~(wr_eoi ? eoi_onehot : '0)) |
                   (ack_take ? vec_onehot : '0);

    edge_sel_d = wr_esel ? cfg_wdata[NUM_IRQ-1:0] : edge_sel_q;
    ep_clr     = (wr_pend ? cfg_wdata[NUM_IRQ-1:0] : '0) |
                 ((ack_take && edge_sel_q[vector_q]) ? vec_onehot : '0);
    edge_pend_d = ((edge_pend_q & ~ep_clr) | (rise & edge_sel_q)) & edge_sel_d;

    rd_word = '0;
    case (cfg_addr)
      ADDR_MASK: rd_word[NUM_IRQ-1:0] = mask_q;
      ADDR_ESEL: rd_word[NUM_IRQ-1:0] = edge_sel_q;
      ADDR_PEND: rd_word[NUM_IRQ-1:0] = eff_pend;
      default:   rd_word[NUM_IRQ-1:0] = in_service_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!arst) begin
      state_q      <= ST_IDLE;
      vector_q     <= '0;
      irq_out      <= 1'b0;
      mask_q       <= '0;
      edge_sel_q   <= '0;
      edge_pend_q  <= '0;
      in_service_q <= '0;
      cfg_rdata    <= '0;
    end else begin
      state_q      <= state_d;
      vector_q     <= vector_d;
      irq_out      <= (state_d == ST_REQ);
      edge_sel_q   <= edge_sel_d;
      edge_pend_q  <= edge_pend_d;
      in_service_q <= in_service_d;
      if (wr_mask) mask_q <= cfg_wdata[NUM_IRQ-1:0];
      if (cfg_rd) cfg_rdata <= rd_word;
    end
  end

  assign irq_vector = vector_q;

endmodule
`default_nettype wire
